// File: rtl/ranger_pkg.sv
// Shared state encoding, fixed constants and parameter-derived helpers for the ultrasonic ranger.
// Derived timing constants are functions so each instance can size itself from its own parameters.
package ranger_pkg;

  typedef enum logic [2:0] {
    TRIG_S = 3'd0,
    WAIT_S = 3'd1,
    MEAS_S = 3'd2,
    DONE_S = 3'd3,
    HOLD_S = 3'd4
  } state_e;

  localparam int CM_US  = 58;
  localparam int DIST_W = 9;

  function automatic int usCycles(input int clkFreq);
    return clkFreq / 1000000;
  endfunction

  function automatic int trigCycles(input int clkFreq, input int trigUs);
    return trigUs * usCycles(clkFreq);
  endfunction

  function automatic int periodCycles(input int clkFreq, input int periodMs);
    return periodMs * (clkFreq / 1000);
  endfunction

  // Bits needed to hold 0..maxVal, never less than one.
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running microsecond tick: one registered single-cycle pulse every CLK_FREQ/1e6 clocks.
module us_tick_gen
  import ranger_pkg::*;
#(
  parameter int CLK_FREQ = 50000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int US_CYC = usCycles(CLK_FREQ);
  localparam int CNT_W  = cntWidth(US_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(US_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    tick_d = (cnt_q == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width to centimetres, and a single
// active-low play request after HITS consecutive near readings.
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 25000,
  parameter int NEAR_CM    = 10,
  parameter int HITS       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              near,
  output logic              echo_sig_n,
  output logic              error
);

  localparam int TRIG_CYC   = trigCycles(CLK_FREQ, TRIG_US);
  localparam int PERIOD_CYC = periodCycles(CLK_FREQ, PERIOD_MS);
  localparam int PER_W      = cntWidth(PERIOD_CYC);
  localparam int US_W       = cntWidth(TIMEOUT_US);
  localparam int SUB_W      = cntWidth(CM_US - 1);
  localparam int HIT_W      = cntWidth(HITS);

  localparam logic [PER_W-1:0]  PER_MAX  = PER_W'(PERIOD_CYC);
  localparam logic [PER_W-1:0]  PER_LAST = PER_W'(PERIOD_CYC - 1);
  localparam logic [PER_W-1:0]  TRIG_END = PER_W'(TRIG_CYC);
  localparam logic [US_W-1:0]   US_MAX   = US_W'(TIMEOUT_US);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(CM_US - 1);
  localparam logic [HIT_W-1:0]  HIT_MAX  = HIT_W'(HITS);
  localparam logic [HIT_W-1:0]  HIT_PRE  = HIT_W'(HITS - 1);
  localparam logic [DIST_W-1:0] NEAR_LIM = DIST_W'(NEAR_CM);

  state_e            state_q, state_d;
  logic [PER_W-1:0]  per_q, per_d;
  logic [US_W-1:0]   us_q, us_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [DIST_W-1:0] cm_q, cm_d;
  logic [HIT_W-1:0]  hit_q, hit_d;
  logic              timeout_q, timeout_d;
  logic              trig_q, trig_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              valid_q, valid_d;
  logic              near_q, near_d;
  logic              play_n_q, play_n_d;
  logic              error_q, error_d;
  logic              echo_s1_q, echo_s2_q, echo_prev_q;
  logic              echo_rise, echo_fall;
  logic              tick;

  us_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign echo_rise = echo_s2_q & ~echo_prev_q;
  assign echo_fall = ~echo_s2_q & echo_prev_q;

  always_comb begin
    state_d   = state_q;
    per_d     = (per_q == PER_MAX) ? per_q : per_q + 1'b1;
    us_d      = (tick && us_q != US_MAX) ? us_q + 1'b1 : us_q;
    sub_d     = sub_q;
    cm_d      = cm_q;
    hit_d     = hit_q;
    timeout_d = timeout_q;
    trig_d    = (state_q == TRIG_S) && (per_q < TRIG_END);
    dist_d    = dist_q;
    valid_d   = 1'b0;
    near_d    = near_q;
    play_n_d  = 1'b1;
    error_d   = error_q;

    unique case (state_q)
      TRIG_S: begin
        if (per_q >= TRIG_END) begin
          state_d   = WAIT_S;
          us_d      = '0;
          timeout_d = 1'b0;
        end
      end
      WAIT_S: begin
        // An echo already high when the trigger ends never produces a rise here.
        if (echo_rise) begin
          state_d = MEAS_S;
          cm_d    = '0;
          sub_d   = '0;
          us_d    = '0;
        end else if (us_q >= US_MAX) begin
          state_d   = DONE_S;
          timeout_d = 1'b1;
        end
      end
      MEAS_S: begin
        if (tick) begin
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            cm_d  = (cm_q == '1) ? cm_q : cm_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
        if (echo_fall) begin
          state_d = DONE_S;
        end else if (us_q >= US_MAX) begin
          state_d   = DONE_S;
          timeout_d = 1'b1;
        end
      end
      DONE_S: begin
        if (!timeout_q) begin
          dist_d  = cm_q;
          valid_d = 1'b1;
          error_d = 1'b0;
        end else begin
          error_d = 1'b1;
        end
        // Only the HITS-1 -> HITS step fires, so one request per approach.
        if (!timeout_q && cm_q < NEAR_LIM) begin
          if (hit_q != HIT_MAX) hit_d = hit_q + 1'b1;
          if (hit_q == HIT_PRE) begin
            near_d   = 1'b1;
            play_n_d = 1'b0;
          end
        end else begin
          hit_d  = '0;
          near_d = 1'b0;
        end
        if (per_q >= PER_LAST) begin
          state_d = TRIG_S;
          per_d   = '0;
        end else begin
          state_d = HOLD_S;
        end
      end
      HOLD_S: begin
        if (per_q >= PER_LAST) begin
          state_d = TRIG_S;
          per_d   = '0;
        end
      end
      default: begin
        state_d = TRIG_S;
        per_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= TRIG_S;
      per_q       <= '0;
      us_q        <= '0;
      sub_q       <= '0;
      cm_q        <= '0;
      hit_q       <= '0;
      timeout_q   <= 1'b0;
      trig_q      <= 1'b0;
      dist_q      <= '0;
      valid_q     <= 1'b0;
      near_q      <= 1'b0;
      play_n_q    <= 1'b1;
      error_q     <= 1'b0;
      echo_s1_q   <= 1'b0;
      echo_s2_q   <= 1'b0;
      echo_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      us_q        <= us_d;
      sub_q       <= sub_d;
      cm_q        <= cm_d;
      hit_q       <= hit_d;
      timeout_q   <= timeout_d;
      trig_q      <= trig_d;
      dist_q      <= dist_d;
      valid_q     <= valid_d;
      near_q      <= near_d;
      play_n_q    <= play_n_d;
      error_q     <= error_d;
      echo_s1_q   <= echo;
      echo_s2_q   <= echo_s1_q;
      echo_prev_q <= echo_s2_q;
    end
  end

  assign trig       = trig_q;
  assign dist_cm    = dist_q;
  assign dist_valid = valid_q;
  assign near       = near_q;
  assign echo_sig_n = play_n_q;
  assign error      = error_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed-plus-random bench for ultrasonic_ranger, scaled to a 2 MHz clock so whole
// measurement periods stay short; expectations come from a measurement-level model.
module tb_ultrasonic_ranger;

  localparam int CLK_FREQ   = 2000000;
  localparam int TRIG_US    = 10;
  localparam int PERIOD_MS  = 1;
  localparam int TIMEOUT_US = 800;
  localparam int NEAR_CM    = 10;
  localparam int HITS       = 3;

  localparam int US_CYC     = CLK_FREQ / 1000000;
  localparam int TRIG_CYC   = TRIG_US * US_CYC;
  localparam int PERIOD_CYC = PERIOD_MS * CLK_FREQ / 1000;

  localparam int MODE_NORMAL  = 0;
  localparam int MODE_NONE    = 1;
  localparam int MODE_PREHIGH = 2;

  logic       clk;
  logic       rst;
  logic       echo;
  logic       trig;
  logic [8:0] dist_cm;
  logic       dist_valid;
  logic       near;
  logic       echo_sig_n;
  logic       error;

  int testCount = 0;
  int failCount = 0;
  int cycle = 0;
  int validCnt = 0;
  int playCnt = 0;
  int validCycle = 0;
  int playCycle = 0;

  int expDist = 0;
  int expErr = 0;
  int expNear = 0;
  int expHit = 0;

  ultrasonic_ranger #(
    .CLK_FREQ  (CLK_FREQ),
    .TRIG_US   (TRIG_US),
    .PERIOD_MS (PERIOD_MS),
    .TIMEOUT_US(TIMEOUT_US),
    .NEAR_CM   (NEAR_CM),
    .HITS      (HITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .echo      (echo),
    .trig      (trig),
    .dist_cm   (dist_cm),
    .dist_valid(dist_valid),
    .near      (near),
    .echo_sig_n(echo_sig_n),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Strobes are counted on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (dist_valid === 1'b1) begin
      validCnt++;
      validCycle = cycle;
    end
    if (echo_sig_n === 1'b0) begin
      playCnt++;
      playCycle = cycle;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int nearWidth();
    return int'($urandom_range(570, 20));
  endfunction

  function automatic int farWidth();
    return int'($urandom_range(750, 580));
  endfunction

  // Model of one measurement: a width below the timeout yields floor(width/58) cm.
  task automatic modelMeasure(input int mode, input int widthUs,
                              output int expValidCnt, output int expPlayCnt);
    int cm;
    expValidCnt = 0;
    expPlayCnt  = 0;
    if (mode == MODE_NORMAL && widthUs < TIMEOUT_US) begin
      cm = widthUs / 58;
      if (cm > 511) cm = 511;
      expDist     = cm;
      expErr      = 0;
      expValidCnt = 1;
      if (cm < NEAR_CM) begin
        if (expHit == HITS - 1) begin
          expNear    = 1;
          expPlayCnt = 1;
        end
        if (expHit < HITS) expHit++;
      end else begin
        expHit  = 0;
        expNear = 0;
      end
    end else begin
      expErr  = 1;
      expHit  = 0;
      expNear = 0;
    end
  endtask

  task automatic modelReset();
    expDist = 0;
    expErr  = 0;
    expNear = 0;
    expHit  = 0;
  endtask

  // Entered just after a trigger rise; leaves just after the next one.
  task automatic applyStimulus(input int mode, input int delayUs, input int widthUs);
    int riseCycle;
    int hi;
    bit found;
    int expValidCnt;
    int expPlayCnt;
    riseCycle = cycle;
    validCnt  = 0;
    playCnt   = 0;
    if (mode == MODE_PREHIGH) echo = 1'b1;
    hi = 0;
    while (trig === 1'b1 && hi < 4 * TRIG_CYC) begin
      stepCycles(1);
      hi++;
    end
    checkOutput("trig_width", hi, TRIG_CYC);
    if (mode == MODE_NORMAL) begin
      stepCycles(delayUs * US_CYC);
      echo = 1'b1;
      stepCycles(widthUs * US_CYC);
      echo = 1'b0;
    end else if (mode == MODE_PREHIGH) begin
      stepCycles(widthUs * US_CYC - TRIG_CYC);
      echo = 1'b0;
    end
    found = 1'b0;
    for (int i = 0; i < 2 * PERIOD_CYC && !found; i++) begin
      stepCycles(1);
      if (trig === 1'b1) found = 1'b1;
    end
    checkOutput("trig_rise_seen", found, 1);
    checkOutput("period", cycle - riseCycle, PERIOD_CYC);
    modelMeasure(mode, widthUs, expValidCnt, expPlayCnt);
    checkOutput("dist_cm", dist_cm, expDist);
    checkOutput("dist_valid_count", validCnt, expValidCnt);
    checkOutput("error", error, expErr);
    checkOutput("near", near, expNear);
    checkOutput("play_count", playCnt, expPlayCnt);
    if (expPlayCnt == 1) checkOutput("play_with_update", playCycle, validCycle);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_trig"}, trig, 0);
    checkOutput({tag, "_dist_cm"}, dist_cm, 0);
    checkOutput({tag, "_dist_valid"}, dist_valid, 0);
    checkOutput({tag, "_near"}, near, 0);
    checkOutput({tag, "_echo_sig_n"}, echo_sig_n, 1);
    checkOutput({tag, "_error"}, error, 0);
  endtask

  initial begin
    #(200000 * 10);
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst  = 1'b0;
    echo = 1'b0;
    modelReset();
    stepCycles(3);
    checkResetValues("reset");
    rst = 1'b1;
    stepCycles(1);
    checkOutput("trig_after_release", trig, 1);

    applyStimulus(MODE_NORMAL, 30, 580);

    for (int i = 0; i < 4; i++)
      applyStimulus(MODE_NORMAL, int'($urandom_range(60, 5)), nearWidth());
    applyStimulus(MODE_NORMAL, 10, 290);

    stepCycles(5);
    checkOutput("pre_reset_trig", trig, 1);
    rst = 1'b0;
    #1;
    checkResetValues("mid_trig_reset");
    stepCycles(2);
    rst = 1'b1;
    modelReset();
    stepCycles(1);
    checkOutput("trig_after_rereset", trig, 1);

    applyStimulus(MODE_NORMAL, 20, nearWidth());
    applyStimulus(MODE_NORMAL, 20, nearWidth());
    applyStimulus(MODE_NORMAL, 20, farWidth());
    for (int i = 0; i < 3; i++)
      applyStimulus(MODE_NORMAL, int'($urandom_range(60, 5)), nearWidth());

    applyStimulus(MODE_NONE, 0, 0);
    applyStimulus(MODE_NORMAL, 15, 580);

    applyStimulus(MODE_PREHIGH, 0, 900);
    applyStimulus(MODE_NORMAL, 25, 20);
    applyStimulus(MODE_NORMAL, 20, 900);
    applyStimulus(MODE_NORMAL, 5, 57);

    for (int i = 0; i < 3; i++) begin
      if ($urandom_range(1, 0) == 1)
        applyStimulus(MODE_NORMAL, int'($urandom_range(60, 5)), nearWidth());
      else
        applyStimulus(MODE_NORMAL, int'($urandom_range(60, 5)), farWidth());
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
- Upstream stage for the pet state machine: drives an HC-SR04-style ultrasonic sensor and measures echo pulse width in centimetres.
- Converts "hand held near the sensor" into a single active-low one-cycle play request, echo_sig_n, which the state machine consumes on its echo_sig1 input.
- Exports raw distance and status for display and debug.

Parameters:
- CLK_FREQ, 50000000: system clock in Hz.
- TRIG_US, 10: trigger pulse width in microseconds.
- PERIOD_MS, 60: measurement repetition period in ms, counted from trigger rise to next trigger rise.
- TIMEOUT_US, 25000: maximum wait for echo rise, and maximum echo width, in microseconds.
- NEAR_CM, 10: a reading strictly below this value counts as near.
- HITS, 3: consecutive near readings required to fire a play request.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- echo  in  1  raw sensor echo, asynchronous to clk.
- trig  out  1  sensor trigger.
- dist_cm  out  9  last valid distance in cm, saturating at 511.
- dist_valid  out  1  one-cycle strobe when dist_cm updates.
- near  out  1  level, high while the near condition is latched.
- echo_sig_n  out  1  active-low one-cycle play request.
- error  out  1  last measurement timed out; cleared by the next valid reading.

Behaviour:
- Reset values, applied asynchronously while rst=0:
  - trig=0, dist_cm=0, dist_valid=0, near=0, echo_sig_n=1, error=0.
  - All counters cleared; state=TRIG_S.
  - Reset mid-pulse drops trig in the same instant.
- echo passes through a 2-flop synchronizer. All echo edges are seen 2 clk late; widths are unaffected.
- A microsecond tick fires every US_CYCLES = CLK_FREQ/1000000 clk (50). It free-runs from reset and drives all time counts.
- Period counter:
  - Restarts to 0 on every entry to TRIG_S.
  - Counts clk cycles up to PERIOD_MS*CLK_FREQ/1000.
- TRIG_S:
  - trig=1 for exactly TRIG_US*US_CYCLES clk (500 at defaults).
  - Then go to WAIT_S and clear the us counter.
- WAIT_S:
  - Synchronized echo rising edge: go to MEAS_S; clear the cm counter and the 58-us subcounter.
  - us counter reaches TIMEOUT_US first: go to DONE_S with timeout flag set.
- MEAS_S:
  - On each us tick, increment the subcounter. When it reaches 58, wrap it to 0 and increment the cm counter (saturating at 511).
  - Falling echo: go to DONE_S with a valid reading.
  - Echo still high when the us counter reaches TIMEOUT_US: go to DONE_S with timeout.
- DONE_S lasts one clk:
  - Valid reading: dist_cm<=cm counter, dist_valid=1, error<=0.
  - Timeout: dist_cm held, dist_valid=0, error<=1.
  - Near logic, below.
  - Then go to HOLD_S.
- HOLD_S: wait until the period counter reaches its terminal value, then go to TRIG_S.
  - An echo arriving in HOLD_S is ignored.
  - If a measurement overruns the period, TRIG_S is entered directly from DONE_S.
- Near logic, evaluated in DONE_S only:
  - Valid and cm<NEAR_CM: hit_cnt increments, saturating at HITS.
  - Any other outcome (far reading or timeout): hit_cnt<=0 and near<=0. This re-arms the request.
  - When hit_cnt transitions HITS-1 -> HITS: near<=1 and echo_sig_n=0 for exactly the next clk.
  - Further near readings while near=1 produce no new request. One play request is fired per approach.
- A distance of 0 cm (echo < 58 us) is valid and counts as near.
- echo already high when TRIG_S ends: no rising edge is seen; WAIT_S times out and error=1.

Decomposition:
- Shared package ranger_pkg holds:
  - state encodings TRIG_S, WAIT_S, MEAS_S, DONE_S, HOLD_S (3-bit);
  - derived constants US_CYCLES, CM_US=58, TRIG_CYC, PERIOD_CYC;
  - counter widths computed from the parameters.
- One natural sub-module, us_tick_gen: parameter CLK_FREQ; ports clk, rst, tick. It emits a one-cycle pulse every US_CYCLES clk.

Test Plan:
- Release reset -> trig rises 1 clk later, stays high 500 clk, next trig rise 3000000 clk after the first.
- echo high 580 us -> dist_cm=10, dist_valid strobe 1 clk, near=0 (10 is not <10), error=0.
- Three consecutive 290 us echoes (5 cm) -> hit_cnt 1,2,3; echo_sig_n low exactly 1 clk after the third DONE_S; near=1. A fourth near reading gives no pulse.
- Two near readings, one 1160 us reading (20 cm), then three near readings -> exactly one echo_sig_n pulse, after the final third near reading.
- echo never rises -> error=1 about 25000 us after trig falls, dist_cm unchanged; a following 580 us echo -> error=0, dist_cm=10.
- echo held high 30 ms -> error=1, near=0. rst pulsed low during TRIG_S -> trig=0 immediately, all outputs at reset values, restart on release.
